// File: rtl/gelato_rf_bank_arbiter.sv
// Register-file bank arbiter: per-bank round-robin grant of operand reads,
// register-0 bypass, and one-cycle routing of bank read data back to the slot.
module gelato_rf_bank_arbiter #(
  parameter int NUM_COLLECTORS = 4,
  parameter int NUM_BANKS      = 4,
  parameter int WARP_NUM_WIDTH = 5,
  parameter int REG_NUM_WIDTH  = 5,
  parameter int WARP_REG_WIDTH = 32,
  localparam int S             = 3 * NUM_COLLECTORS,
  localparam int AW            = WARP_NUM_WIDTH + REG_NUM_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [S-1:0]                        req_valid,
  input  logic [S*WARP_NUM_WIDTH-1:0]         req_warp,
  input  logic [S*REG_NUM_WIDTH-1:0]          req_reg,
  output logic [S-1:0]                        grant,
  input  logic [NUM_BANKS-1:0]                wb_busy,
  output logic [NUM_BANKS-1:0]                bank_rd_en,
  output logic [NUM_BANKS*AW-1:0]             bank_rd_addr,
  input  logic [NUM_BANKS*WARP_REG_WIDTH-1:0] bank_rd_data,
  output logic [S-1:0]                        resp_valid,
  output logic [S*WARP_REG_WIDTH-1:0]         resp_data
);

  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int PW = (S > 1) ? $clog2(S) : 1;

  logic [S-1:0]                  w_cand;
  logic [S-1:0]                  w_bypass;
  logic [BW-1:0]                 w_bankOf [S];
  logic [S-1:0]                  w_bankReq [NUM_BANKS];
  logic [PW:0]                   w_pick [NUM_BANKS];
  logic [S-1:0]                  w_grant;
  logic [NUM_BANKS-1:0]          w_rdEn;
  logic [NUM_BANKS*AW-1:0]       w_rdAddr;
  logic [S-1:0]                  w_respValid;
  logic [S*WARP_REG_WIDTH-1:0]   w_respData;

  logic [PW-1:0]                 r_rrPtr [NUM_BANKS];
  logic [NUM_BANKS-1:0]          r_routeValid;
  logic [PW-1:0]                 r_routeSlot [NUM_BANKS];
  logic [S-1:0]                  r_bypValid;

  // Returns {found, index} of the first set bit at or after ptr, wrapping at S.
  function automatic logic [PW:0] rrPick(input logic [S-1:0] reqs, input logic [PW-1:0] ptr);
    logic [PW:0] result;
    int          idx;
    result = '0;
    for (int i = S - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % S;
      if (reqs[idx]) result = {1'b1, PW'(idx)};
    end
    return result;
  endfunction

  always_comb begin
    w_cand   = '0;
    w_bypass = '0;
    w_bankOf = '{default: '0};
    for (int s = 0; s < S; s++) begin
      w_bankOf[s] = req_warp[s*WARP_NUM_WIDTH +: BW] + req_reg[s*REG_NUM_WIDTH +: BW];
      w_cand[s]   = req_valid[s] && (req_reg[s*REG_NUM_WIDTH +: REG_NUM_WIDTH] != '0);
      w_bypass[s] = req_valid[s] && (req_reg[s*REG_NUM_WIDTH +: REG_NUM_WIDTH] == '0);
    end
  end

  // A bank held by writeback sees no candidates, so its pointer cannot move.
  always_comb begin
    w_bankReq = '{default: '0};
    w_pick    = '{default: '0};
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int s = 0; s < S; s++) begin
        w_bankReq[b][s] = w_cand[s] && (w_bankOf[s] == BW'(b)) && !wb_busy[b];
      end
      w_pick[b] = rrPick(w_bankReq[b], r_rrPtr[b]);
    end
  end

  always_comb begin
    w_grant  = w_bypass;
    w_rdEn   = '0;
    w_rdAddr = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (w_pick[b][PW]) begin
        w_grant[w_pick[b][PW-1:0]] = 1'b1;
        w_rdEn[b]                  = 1'b1;
        w_rdAddr[b*AW +: AW] = {req_warp[int'(w_pick[b][PW-1:0])*WARP_NUM_WIDTH +: WARP_NUM_WIDTH],
                                req_reg[int'(w_pick[b][PW-1:0])*REG_NUM_WIDTH +: REG_NUM_WIDTH]};
      end
    end
  end

  // Bypassed slots answer with zero data; bank routes steer read data to their slot.
  always_comb begin
    w_respValid = r_bypValid;
    w_respData  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (r_routeValid[b]) begin
        w_respValid[r_routeSlot[b]] = 1'b1;
        w_respData[int'(r_routeSlot[b])*WARP_REG_WIDTH +: WARP_REG_WIDTH] =
          bank_rd_data[b*WARP_REG_WIDTH +: WARP_REG_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_routeValid <= '0;
      r_bypValid   <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_rrPtr[b]     <= '0;
        r_routeSlot[b] <= '0;
      end
    end else begin
      r_bypValid <= w_bypass;
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_routeValid[b] <= w_pick[b][PW];
        r_routeSlot[b]  <= w_pick[b][PW-1:0];
        if (w_pick[b][PW]) begin
          r_rrPtr[b] <= (int'(w_pick[b][PW-1:0]) == S - 1) ? '0 : w_pick[b][PW-1:0] + 1'b1;
        end
      end
    end
  end

  assign grant        = rst ? '0 : w_grant;
  assign bank_rd_en   = rst ? '0 : w_rdEn;
  assign bank_rd_addr = rst ? '0 : w_rdAddr;
  assign resp_valid   = rst ? '0 : w_respValid;
  assign resp_data    = rst ? '0 : w_respData;

endmodule
